muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port ctrl_bus  modport ctrl_bus_if.central  --  provides ctrl_bus.clk (single clock, all state on rising edge) and ctrl_bus.reset (synchronous, active-high).
REQ-003 SHALL have port start  in  1  --  begin the operation selected by op.
REQ-004 SHALL have port op  in  2  --  muldiv_op_t: MD_MULT=00, MD_MULTU=01, MD_DIV=10, MD_DIVU=11.
REQ-005 SHALL have port rs_data  in  32  --  register-file source operand (multiplicand/dividend; mthi/mtlo data).
REQ-006 SHALL have port rt_data  in  32  --  register-file source operand (multiplier/divisor).
REQ-007 SHALL have port mthi  in  1  --  write rs_data to HI.
REQ-008 SHALL have port mtlo  in  1  --  write rs_data to LO.
REQ-009 SHALL have port busy  out  1  --  operation in progress; the CPU stalls on it.
REQ-010 SHALL have port done  out  1  --  one-cycle pulse; HI/LO hold a new result.
REQ-011 SHALL have port div_by_zero  out  1  --  pulses with done when a divide had rt_data==0.
REQ-012 SHALL have ports hi, lo  out  32 each  --  registered HI/LO, read by mfhi/mflo.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX.
REQ-014 SHALL, in IDLE with start=1, latch rs_data, rt_data and op at edge E0 and enter CALC; later operand changes have no effect.
REQ-015 SHALL, in CALC, run one iteration per cycle for 32 cycles (edges E1..E32), driven by a 5-bit down-counter loaded with 31 at E0; at count 0 it enters FIX.
REQ-016 SHALL multiply by shift-add on magnitudes into a 64-bit accumulator, and divide by restoring division on magnitudes (32-bit quotient, 32-bit remainder).
REQ-017 SHALL, for MD_MULT/MD_DIV, take operand magnitudes at E0 and apply the sign in FIX: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign. MD_MULTU/MD_DIVU SHALL use raw operands with no sign handling.
REQ-018 SHALL, at edge E33 (FIX->IDLE), write HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
REQ-019 SHALL assert busy in every cycle from after E0 through E33 (33 cycles); busy=0 in IDLE.
REQ-020 SHALL assert done for exactly the one cycle after E33, in which hi/lo already show the new values and busy=0.
REQ-021 SHALL, for divide with rt_data==0, produce LO=32'hFFFF_FFFF and HI=latched rs_data, with div_by_zero=1 alongside done, using the same latency.
REQ-022 SHALL, for MD_DIV 0x8000_0000 / 0xFFFF_FFFF, produce LO=0x8000_0000 and HI=0 with no exception.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL honour mthi/mtlo only in IDLE with start=0, updating HI/LO at the next edge; they SHALL be ignored while busy or when start=1 in the same cycle.
REQ-025 SHALL, with mthi and mtlo both asserted, write both registers.

Reset
REQ-026 SHALL, at any edge with ctrl_bus.reset=1, including mid-CALC or FIX, set state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 and div_by_zero=0, and abandon any in-flight result.
REQ-027 SHALL give reset priority over start, mthi and mtlo.

Structure
REQ-028 SHALL place muldiv_op_t, the FSM state enum, and the constants WIDTH=32 and ITER=32 in shared package muldiv_pkg.
REQ-029 SHALL be a single module with no sub-module, keeping accumulator, counter and FSM local.

Verification
REQ-030 SHALL verify MD_MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001, with done exactly 34 cycles after the start cycle.
REQ-031 SHALL verify MD_MULT -3*5 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; and MD_DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
REQ-032 SHALL verify MD_DIVU 100/0 -> LO=0xFFFF_FFFF, HI=100, div_by_zero=1 only in the done cycle.
REQ-033 SHALL verify MD_DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
REQ-034 SHALL verify reset asserted 10 cycles into a MULT -> next cycle busy=0, hi=lo=0, no done pulse afterwards.
REQ-035 SHALL verify that start during busy is ignored (only one done); mthi=1 with rs_data=0x1234 in IDLE gives hi=0x1234 next cycle; mthi with start in the same cycle gives hi unchanged by mthi.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle shared by the execute-stage helper units.
interface ctrl_bus_if;

  logic clk;
  logic reset;

  modport central (input clk, input reset);
  modport source  (output clk, output reset);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  ctrl_bus_if.central      ctrl_bus,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);

  md_state_t          state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   rs_q;
  logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;

  logic               signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state logic: start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand magnitudes and one iteration of each algorithm, plus final sign fix-up.
  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[WIDTH-1];
    rt_neg    = signed_op & rt_data[WIDTH-1];
    mag_a     = rs_neg ? -rs_data : rs_data;
    mag_b     = rt_neg ? -rt_data : rt_data;

    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    mul_step = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted[WIDTH-1:0] - operand;
    if (shifted >= {1'b0, operand}) div_step = {diff, acc[WIDTH-2:0], 1'b1};
    else                            div_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    product = neg_res_q ? -acc : acc;
    quot    = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    res_hi = product[2*WIDTH-1:WIDTH];
    res_lo = product[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  // Datapath: latch operands, iterate, then commit HI/LO; mthi/mtlo only when idle.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      count       <= '0;
      acc         <= '0;
      operand     <= '0;
      rs_q        <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count      <= CNT_LOAD;
            rs_q       <= rs_data;
            is_div_q   <= op[1];
            neg_res_q  <= rs_neg ^ rt_neg;
            neg_rem_q  <= rs_neg;
            div_zero_q <= op[1] & (rt_data == '0);
            operand    <= op[1] ? mag_b : mag_a;
            acc        <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          end else begin
            if (mthi) hi <= rs_data;
            if (mtlo) lo <= rs_data;
          end
        end
        CALC: begin
          acc <= is_div_q ? div_step : mul_step;
          if (count != '0) count <= count - 1'b1;
        end
        FIX: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= div_zero_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for reset, busy-time start and mthi/mtlo behaviour.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  ctrl_bus_if ctrl_bus();

  logic        start, mthi, mtlo;
  muldiv_op_t  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } vec_t;

  vec_t vecs[10];

  muldiv_unit #(.WIDTH(32)) dut (
    .ctrl_bus   (ctrl_bus),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial ctrl_bus.clk = 1'b0;
  always #5 ctrl_bus.clk = ~ctrl_bus.clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ctrl_bus.clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic void ref_model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      MD_MULT: begin
        p  = sa * sb;
        eh = p[63:32];
        el = p[31:0];
      end
      MD_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ed = 1'b1;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ed = 1'b1;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Issue one operation, scramble operands after the latch edge, then check
  // busy over the whole run, done latency, result and the done pulse width.
  task automatic applyStimulus(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el, input logic ed,
                               input string name);
    int n;
    int busy_bad;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    tick();
    start    = 1'b0;
    rs_data  = $urandom;
    rt_data  = $urandom;
    n        = 1;
    busy_bad = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      n++;
    end
    checkOutput({name, " latency"}, 64'(n), 64'd34);
    checkOutput({name, " busy run"}, 64'(busy_bad), 64'd0);
    checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({name, " hi"}, 64'(hi), 64'(eh));
    checkOutput({name, " lo"}, 64'(lo), 64'(el));
    checkOutput({name, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    tick();
    checkOutput({name, " done width"}, 64'(done), 64'd0);
    checkOutput({name, " dbz width"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el, a, b, cap_hi, cap_lo;
    logic        ed, cap_dbz;
    muldiv_op_t  ro;
    int          done_cnt;

    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max"};
    vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult -3*5"};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"};
    vecs[3] = '{MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, "divu 100/0"};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div overflow"};
    vecs[5] = '{MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, "divu 7/2"};
    vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, "div 7/-2"};
    vecs[7] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0, "div -7/-2"};
    vecs[8] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div -5/0"};
    vecs[9] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult minint^2"};

    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = MD_MULT;
    rs_data = '0; rt_data = '0;
    ctrl_bus.reset = 1'b1;
    tick();
    tick();
    ctrl_bus.reset = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset dbz", 64'(div_by_zero), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].name);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      ref_model(ro, a, b, eh, el, ed);
      applyStimulus(ro, a, b, eh, el, ed, $sformatf("rand%0d op%0d", i, ro));
    end

    // Reset ten cycles into a multiply abandons it.
    start = 1'b1; op = MD_MULT; rs_data = 32'd7; rt_data = 32'd9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    ctrl_bus.reset = 1'b1;
    tick();
    ctrl_bus.reset = 1'b0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset hi", 64'(hi), 64'd0);
    checkOutput("midreset lo", 64'(lo), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    done_cnt = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("midreset no late done", 64'(done_cnt), 64'd0);

    // Reset wins over start in the same cycle.
    ctrl_bus.reset = 1'b1; start = 1'b1; op = MD_MULTU;
    tick();
    ctrl_bus.reset = 1'b0; start = 1'b0;
    tick();
    checkOutput("reset over start busy", 64'(busy), 64'd0);

    // Start and mthi/mtlo while busy are ignored.
    start = 1'b1; op = MD_MULTU; rs_data = 32'd6; rt_data = 32'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd0; mthi = 1'b1; mtlo = 1'b1;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    done_cnt = 0; cap_hi = '1; cap_lo = '1; cap_dbz = 1'b1;
    repeat (70) begin
      if (done === 1'b1) begin
        done_cnt++;
        cap_hi = hi; cap_lo = lo; cap_dbz = div_by_zero;
      end
      tick();
    end
    checkOutput("busy start done count", 64'(done_cnt), 64'd1);
    checkOutput("busy start hi", 64'(cap_hi), 64'd0);
    checkOutput("busy start lo", 64'(cap_lo), 64'd42);
    checkOutput("busy start dbz", 64'(cap_dbz), 64'd0);

    // mthi / mtlo / both in IDLE.
    rs_data = 32'h1234; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    checkOutput("mthi hi", 64'(hi), 64'h1234);
    checkOutput("mthi lo kept", 64'(lo), 64'd42);
    rs_data = 32'h5678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    checkOutput("mtlo lo", 64'(lo), 64'h5678);
    checkOutput("mtlo hi kept", 64'(hi), 64'h1234);
    rs_data = 32'hABCD; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("mthi+mtlo hi", 64'(hi), 64'hABCD);
    checkOutput("mthi+mtlo lo", 64'(lo), 64'hABCD);

    // mthi together with start: the operation runs, mthi is dropped.
    start = 1'b1; mthi = 1'b1; op = MD_MULTU; rs_data = 32'd2; rt_data = 32'd3;
    tick();
    start = 1'b0; mthi = 1'b0;
    checkOutput("mthi+start hi", 64'(hi), 64'hABCD);
    checkOutput("mthi+start busy", 64'(busy), 64'd1);
    done_cnt = 0;
    while (done !== 1'b1 && done_cnt < 40) begin
      tick();
      done_cnt++;
    end
    checkOutput("mthi+start result hi", 64'(hi), 64'd0);
    checkOutput("mthi+start result lo", 64'(lo), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
